feature_word_serializer: RTL and testbench
==========================================

// Module: feature_word_serializer
// PURPOSE
// - Read-side counterpart of aligned_feature_loader: drains one wide column vector
//   (aflDimY elements x elementWidth bits) from the array into a stream of
//   inputWidth-bit words with valid/ready flow control.
// - Each word carries a word address (base offset + word index), so the downstream
//   buffer or bus can write it back in the packing the loader consumes.
// PARAMETERS
// - aflDimY       128  elements per captured column vector
// - inputWidth    32   output word width in bits
// - elementWidth  4    bits per element
// - addrWidth     32   width of the address offset and of addr_o
// - derived: inputElements = inputWidth/elementWidth (8)
// - derived: numWords = aflDimY/inputElements (16)
// - elaboration $error if aflDimY % inputElements != 0 or inputWidth % elementWidth != 0
// PORTS
// - clk            in   1                         clock, rising edge
// - nrst           in   1                         asynchronous active-low reset
// - data_i         in   [aflDimY-1:0][elementWidth-1:0]  column vector to drain
// - valid_i        in   1                         capture request for data_i
// - ready_o        out  1                         serializer can capture this cycle
// - addr_offset_i  in   addrWidth                 base word address, sampled on capture
// - data_o         out  inputWidth                current output word
// - valid_o        out  1                         data_o/addr_o/last_o valid
// - ready_i        in   1                         downstream accepts word
// - addr_o         out  addrWidth                 base + word index
// - last_o         out  1                         current word is the final word of vector
// - num_words_i    in   $clog2(numWords+1)        words to emit (only with FWS_WORD_LIMIT_EN)
// BEHAVIOUR
// - Reset values: ready_o=1, valid_o=0, data_o=0, addr_o=0, last_o=0; FSM=IDLE;
//   buffer, base and count cleared.
// - FSM states: IDLE, SEND.
//   - IDLE -> SEND on capture.
//   - SEND -> IDLE on a last-word handshake with no new capture.
//   - SEND -> SEND on a last-word handshake with a simultaneous capture.
// - ready_o = (state==IDLE) | (valid_o & ready_i & last_o): back-to-back vectors,
//   no bubble.
// - Capture = valid_i & ready_o. On capture, register data_i into the buffer,
//   addr_offset_i into base, and clear count to 0.
// - valid_o = (state==SEND). First word is presented the cycle after capture
//   (latency 1).
// - Word k packing: element (k*inputElements + j) occupies
//   data_o[j*elementWidth +: elementWidth], j=0..inputElements-1; element 0 is in the LSBs.
// - Output values:
//   - data_o = buffer word[count].
//   - addr_o = base + count, truncated to addrWidth (wraps modulo 2^addrWidth).
//   - last_o = (count == limit-1).
//   - data_o and addr_o are forced to 0 when valid_o=0.
// - Handshake = valid_o & ready_i. On handshake, count increments; the final handshake
//   ends the vector.
// - Backpressure: while valid_o & !ready_i, data_o, addr_o and last_o hold stable.
// - valid_o never drops without a handshake.
// - valid_i while busy (ready_o=0) is ignored; no capture, no error.
// - Throughput: numWords words in numWords cycles when ready_i=1, plus 0 bubbles
//   across back-to-back vectors.
// - nrst asserted mid-vector aborts the vector immediately (async). The remaining words
//   are lost and outputs return to reset values.
// CONFIGURATION
// - FWS_WORD_LIMIT_EN defined:
//   - num_words_i port is present and sampled on capture.
//   - limit = num_words_i, clamped to numWords.
//   - num_words_i==0 completes the capture with no words emitted: the FSM stays IDLE
//     and ready_o stays 1.
// - FWS_WORD_LIMIT_EN undefined: no num_words_i port; limit = numWords always.
// TESTING
// - Single vector, element i = i[3:0], offset 0x100, ready_i=1:
//   expect 16 words in 16 consecutive cycles; word0=0x76543210, word1=0xFEDCBA98;
//   addr 0x100..0x10F; last_o only on word 15.
// - Backpressure: ready_i toggled 1,0,0,1,... mid-vector:
//   outputs stable during stalls; all 16 words in order; no duplicates or drops.
// - Back-to-back: valid_i held high with two different vectors:
//   second capture coincides with the word-15 handshake; word0 of vector 2 follows
//   in the next cycle with no bubble.
// - Wrap and busy: offset 0xFFFFFFF8 -> addr_o runs 0xFFFFFFF8..0x00000007;
//   a valid_i pulse mid-vector is ignored (ready_o=0).
// - Reset mid-vector: drop nrst after word 5 -> valid_o=0 and ready_o=1 immediately;
//   a new vector restarts at word 0.
// - FWS_WORD_LIMIT_EN:
//   - num_words_i=3 -> 3 words, last_o on word 2.
//   - num_words_i=0 -> no valid_o.
//   - num_words_i=20 -> clamped to 16 words.

Source files
------------

// File: rtl/feature_word_serializer_if.sv
// ---------------------------------------------------------------------------
// feature_word_serializer_if
// Bus bundle for feature_word_serializer: the column-vector capture side
// (data_i/valid_i/ready_o/addr_offset_i) and the word stream side
// (data_o/valid_o/ready_i/addr_o/last_o).
//   master : the serializer view (drives ready_o and the word stream)
//   slave  : the environment view (drives vectors in, accepts words)
// Optional macro FWS_WORD_LIMIT_EN adds num_words_i (per-vector word count).
// ---------------------------------------------------------------------------
interface feature_word_serializer_if #(
   parameter int aflDimY      = 128,
   parameter int inputWidth   = 32,
   parameter int elementWidth = 4,
   parameter int addrWidth    = 32
);
   localparam int numWords = aflDimY / (inputWidth / elementWidth);
   localparam int cntW     = $clog2(numWords + 1);

   logic [aflDimY-1:0][elementWidth-1:0] data_i;
   logic                                 valid_i;
   logic                                 ready_o;
   logic [addrWidth-1:0]                 addr_offset_i;
   logic [inputWidth-1:0]                data_o;
   logic                                 valid_o;
   logic                                 ready_i;
   logic [addrWidth-1:0]                 addr_o;
   logic                                 last_o;
`ifdef FWS_WORD_LIMIT_EN
   logic [cntW-1:0]                      num_words_i;
`endif

   modport master (
`ifdef FWS_WORD_LIMIT_EN
      input  num_words_i,
`endif
      input  data_i, valid_i, addr_offset_i, ready_i,
      output ready_o, data_o, valid_o, addr_o, last_o
   );

   modport slave (
`ifdef FWS_WORD_LIMIT_EN
      output num_words_i,
`endif
      output data_i, valid_i, addr_offset_i, ready_i,
      input  ready_o, data_o, valid_o, addr_o, last_o
   );
endinterface

// File: rtl/feature_word_serializer.sv
// ---------------------------------------------------------------------------
// feature_word_serializer
// Captures one column vector (aflDimY elements x elementWidth bits) and drains
// it as inputWidth-bit words with valid/ready flow control. Each word carries
// addr_o = base offset + word index (wraps modulo 2^addrWidth). Element
// (k*inputElements + j) of word k sits at data_o[j*elementWidth +: elementWidth].
// Ports:
//   clk   : clock, rising edge
//   nrst  : asynchronous active-low reset
//   bus   : feature_word_serializer_if.master
//           capture side  data_i, valid_i, ready_o, addr_offset_i
//           stream side   data_o, valid_o, ready_i, addr_o, last_o
//           num_words_i   (only with FWS_WORD_LIMIT_EN)
// Optional feature macro: FWS_WORD_LIMIT_EN -- per-vector word count taken
// from num_words_i on capture, clamped to numWords; 0 emits nothing.
// ---------------------------------------------------------------------------
module feature_word_serializer #(
   parameter int aflDimY      = 128,
   parameter int inputWidth   = 32,
   parameter int elementWidth = 4,
   parameter int addrWidth    = 32
) (
   input  logic                          clk,
   input  logic                          nrst,
   feature_word_serializer_if.master     bus
);
   localparam int inputElements = inputWidth / elementWidth;
   localparam int numWords      = aflDimY / inputElements;
   localparam int cntW          = $clog2(numWords + 1);
   localparam int idxW          = (numWords > 1) ? $clog2(numWords) : 1;

   if ((inputWidth % elementWidth) != 0) begin : g_bad_elem
      $error("feature_word_serializer: inputWidth must be a multiple of elementWidth");
   end
   if ((aflDimY % inputElements) != 0) begin : g_bad_dim
      $error("feature_word_serializer: aflDimY must be a multiple of inputWidth/elementWidth");
   end

   typedef enum logic {IDLE, SEND} state_e;

   state_e                               state_q;
   // The captured vector viewed as words: same bit layout as data_i, so
   // word k holds elements k*inputElements .. k*inputElements+inputElements-1.
   logic [numWords-1:0][inputWidth-1:0]  buf_q;
   logic [addrWidth-1:0]                 base_q;
   logic [cntW-1:0]                      count_q;
   logic [cntW-1:0]                      limit_q;
   logic [cntW-1:0]                      limit_d;

   logic valid_w, last_w, hs_w, ready_w, capture_w;

`ifdef FWS_WORD_LIMIT_EN
   always_comb begin
      limit_d = bus.num_words_i;
      if (bus.num_words_i > cntW'(numWords)) limit_d = cntW'(numWords);
   end
`else
   assign limit_d = cntW'(numWords);
`endif

   assign valid_w   = (state_q == SEND);
   assign last_w    = (count_q == (limit_q - cntW'(1)));
   assign hs_w      = valid_w & bus.ready_i;
   // Accept a new vector in the same cycle the last word leaves: no bubble.
   assign ready_w   = ~valid_w | (hs_w & last_w);
   assign capture_w = bus.valid_i & ready_w;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= IDLE;
         buf_q   <= '0;
         base_q  <= '0;
         count_q <= '0;
         limit_q <= '0;
      end else begin
         if (capture_w) begin
            // A capture always wins over the last-word handshake it overlaps.
            buf_q   <= bus.data_i;
            base_q  <= bus.addr_offset_i;
            count_q <= '0;
            limit_q <= limit_d;
            state_q <= (limit_d == '0) ? IDLE : SEND;
         end else if (hs_w) begin
            if (last_w) state_q <= IDLE;
            else        count_q <= count_q + cntW'(1);
         end
      end
   end

   assign bus.ready_o = ready_w;
   assign bus.valid_o = valid_w;
   assign bus.last_o  = valid_w & last_w;
   assign bus.data_o  = valid_w ? buf_q[count_q[idxW-1:0]] : '0;
   assign bus.addr_o  = valid_w ? (base_q + addrWidth'(count_q)) : '0;

endmodule

// File: tb/tb_feature_word_serializer.sv
module tb_feature_word_serializer;
   localparam int DY = 128, IW = 32, EW = 4, AW = 32, NW = 16;

   logic clk = 1'b0;
   logic nrst;
   always #5 clk = ~clk;

   feature_word_serializer_if #(.aflDimY(DY), .inputWidth(IW), .elementWidth(EW),
                                .addrWidth(AW)) bus ();

   feature_word_serializer #(.aflDimY(DY), .inputWidth(IW), .elementWidth(EW),
                             .addrWidth(AW)) dut (.clk(clk), .nrst(nrst), .bus(bus));

   int n_chk  = 0;
   int n_pass = 0;

   logic [DY-1:0][EW-1:0] vec_a, vec_b;
   logic [65:0] got, exp;
   logic [31:0] ea;

   // vec_a: element i = i[3:0]; vec_b: element i = ~i[3:0]
   function automatic logic [31:0] exp_word(bit second, int k);
      if (!second) return (k % 2 == 0) ? 32'h76543210 : 32'hFEDCBA98;
      return (k % 2 == 0) ? 32'h89ABCDEF : 32'h01234567;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input logic [DY-1:0][EW-1:0] v, input logic [31:0] off);
      bus.valid_i       = 1'b1;
      bus.data_i        = v;
      bus.addr_offset_i = off;
      step();
      bus.valid_i       = 1'b0;
   endtask

   task automatic test_reset();
      nrst = 1'b0;
      #2;
      n_chk++;
      got = {31'd0, bus.ready_o, bus.valid_o, bus.last_o, bus.addr_o, bus.data_o};
      exp = {31'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0};
      if (got !== exp) $display("FAIL reset_values got %h exp %h", got, exp);
      else n_pass++;
      #1 nrst = 1'b1;
      step();
      step();
      n_chk++;
      if ({bus.ready_o, bus.valid_o} !== 2'b10)
         $display("FAIL idle_after_reset got %b exp 10", {bus.ready_o, bus.valid_o});
      else n_pass++;
   endtask

   task automatic test_single();
      bus.ready_i = 1'b1;
      n_chk++;
      if (bus.ready_o !== 1'b1) $display("FAIL single_ready got %b exp 1", bus.ready_o);
      else n_pass++;
      start(vec_a, 32'h100);
      for (int k = 0; k < NW; k++) begin
         ea = 32'h100 + 32'(k);
         n_chk++;
         got = {bus.valid_o, bus.last_o, bus.addr_o, bus.data_o};
         exp = {1'b1, (k == NW - 1), ea, exp_word(1'b0, k)};
         if (got !== exp) $display("FAIL single_word%0d got %h exp %h", k, got, exp);
         else n_pass++;
         step();
      end
      n_chk++;
      if ({bus.valid_o, bus.ready_o} !== 2'b01)
         $display("FAIL single_end got %b exp 01", {bus.valid_o, bus.ready_o});
      else n_pass++;
   endtask

   task automatic test_backpressure();
      int pat [4] = '{1, 0, 0, 1};
      int k = 0;
      int c = 0;
      bus.ready_i = 1'b1;
      start(vec_a, 32'h100);
      while (k < NW && c < 100) begin
         bus.ready_i = pat[c % 4][0];
         #1;
         ea = 32'h100 + 32'(k);
         n_chk++;
         got = {bus.valid_o, bus.last_o, bus.addr_o, bus.data_o};
         exp = {1'b1, (k == NW - 1), ea, exp_word(1'b0, k)};
         if (got !== exp) $display("FAIL bp_cycle%0d_word%0d got %h exp %h", c, k, got, exp);
         else n_pass++;
         n_chk++;
         if (bus.ready_o !== (bus.ready_i && k == NW - 1))
            $display("FAIL bp_ready_cycle%0d got %b exp %b", c, bus.ready_o,
                     (bus.ready_i && k == NW - 1));
         else n_pass++;
         if (bus.ready_i) k++;
         c++;
         step();
      end
      n_chk++;
      if (k != NW) $display("FAIL bp_timeout words %0d exp %0d", k, NW);
      else n_pass++;
      bus.ready_i = 1'b1;
      #1;
      n_chk++;
      if (bus.valid_o !== 1'b0) $display("FAIL bp_end_valid got %b exp 0", bus.valid_o);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      bus.ready_i       = 1'b1;
      bus.valid_i       = 1'b1;
      bus.data_i        = vec_a;
      bus.addr_offset_i = 32'h200;
      step();
      bus.data_i        = vec_b;
      bus.addr_offset_i = 32'h300;
      #1;
      for (int k = 0; k < NW; k++) begin
         ea = 32'h200 + 32'(k);
         n_chk++;
         got = {bus.valid_o, bus.last_o, bus.addr_o, bus.data_o};
         exp = {1'b1, (k == NW - 1), ea, exp_word(1'b0, k)};
         if (got !== exp) $display("FAIL b2b_a_word%0d got %h exp %h", k, got, exp);
         else n_pass++;
         n_chk++;
         if (bus.ready_o !== (k == NW - 1))
            $display("FAIL b2b_ready%0d got %b exp %b", k, bus.ready_o, (k == NW - 1));
         else n_pass++;
         step();
      end
      bus.valid_i = 1'b0;
      #1;
      for (int k = 0; k < NW; k++) begin
         ea = 32'h300 + 32'(k);
         n_chk++;
         got = {bus.valid_o, bus.last_o, bus.addr_o, bus.data_o};
         exp = {1'b1, (k == NW - 1), ea, exp_word(1'b1, k)};
         if (got !== exp) $display("FAIL b2b_b_word%0d got %h exp %h", k, got, exp);
         else n_pass++;
         step();
      end
      n_chk++;
      if (bus.valid_o !== 1'b0) $display("FAIL b2b_end_valid got %b exp 0", bus.valid_o);
      else n_pass++;
   endtask

   task automatic test_wrap_busy();
      bus.ready_i = 1'b1;
      start(vec_b, 32'hFFFF_FFF8);
      for (int k = 0; k < NW; k++) begin
         if (k == 4) begin
            bus.valid_i       = 1'b1;
            bus.data_i        = vec_a;
            bus.addr_offset_i = 32'h0;
            #1;
            n_chk++;
            if (bus.ready_o !== 1'b0) $display("FAIL busy_ready got %b exp 0", bus.ready_o);
            else n_pass++;
         end
         ea = 32'hFFFF_FFF8 + 32'(k);
         n_chk++;
         got = {bus.valid_o, bus.last_o, bus.addr_o, bus.data_o};
         exp = {1'b1, (k == NW - 1), ea, exp_word(1'b1, k)};
         if (got !== exp) $display("FAIL wrap_word%0d got %h exp %h", k, got, exp);
         else n_pass++;
         step();
         bus.valid_i = 1'b0;
      end
      n_chk++;
      if ({bus.valid_o, bus.ready_o} !== 2'b01)
         $display("FAIL wrap_end got %b exp 01", {bus.valid_o, bus.ready_o});
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      bus.ready_i = 1'b1;
      start(vec_a, 32'h100);
      for (int k = 0; k < 6; k++) step();
      nrst = 1'b0;
      #1;
      n_chk++;
      got = {31'd0, bus.ready_o, bus.valid_o, bus.last_o, bus.addr_o, bus.data_o};
      exp = {31'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0};
      if (got !== exp) $display("FAIL reset_mid got %h exp %h", got, exp);
      else n_pass++;
      #1 nrst = 1'b1;
      step();
      start(vec_b, 32'h40);
      for (int k = 0; k < NW; k++) begin
         ea = 32'h40 + 32'(k);
         n_chk++;
         got = {bus.valid_o, bus.last_o, bus.addr_o, bus.data_o};
         exp = {1'b1, (k == NW - 1), ea, exp_word(1'b1, k)};
         if (got !== exp) $display("FAIL restart_word%0d got %h exp %h", k, got, exp);
         else n_pass++;
         step();
      end
      n_chk++;
      if (bus.valid_o !== 1'b0) $display("FAIL restart_end got %b exp 0", bus.valid_o);
      else n_pass++;
   endtask

`ifdef FWS_WORD_LIMIT_EN
   task automatic test_word_limit();
      int lims [3] = '{3, 0, 20};
      int nexp;
      bus.ready_i = 1'b1;
      for (int t = 0; t < 3; t++) begin
         nexp = (lims[t] > NW) ? NW : lims[t];
         bus.num_words_i = 5'(lims[t]);
         start(vec_a, 32'h500);
         for (int k = 0; k < nexp; k++) begin
            ea = 32'h500 + 32'(k);
            n_chk++;
            got = {bus.valid_o, bus.last_o, bus.addr_o, bus.data_o};
            exp = {1'b1, (k == nexp - 1), ea, exp_word(1'b0, k)};
            if (got !== exp) $display("FAIL limit%0d_word%0d got %h exp %h", lims[t], k, got, exp);
            else n_pass++;
            step();
         end
         for (int k = 0; k < 3; k++) begin
            n_chk++;
            if ({bus.valid_o, bus.ready_o} !== 2'b01)
               $display("FAIL limit%0d_idle%0d got %b exp 01", lims[t], k,
                        {bus.valid_o, bus.ready_o});
            else n_pass++;
            step();
         end
      end
      bus.num_words_i = 5'(NW);
   endtask
`endif

   initial begin
      for (int i = 0; i < DY; i++) begin
         vec_a[i] = 4'(i);
         vec_b[i] = 4'(15 - (i % 16));
      end
      bus.valid_i       = 1'b0;
      bus.data_i        = '0;
      bus.addr_offset_i = '0;
      bus.ready_i       = 1'b0;
`ifdef FWS_WORD_LIMIT_EN
      bus.num_words_i   = 5'(NW);
`endif
      test_reset();
      test_single();
      test_backpressure();
      test_back_to_back();
      test_wrap_busy();
      test_reset_mid();
`ifdef FWS_WORD_LIMIT_EN
      test_word_limit();
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1, "timeout");
   end
endmodule
